// File: rtl/rv32i_pipeline_core.sv
// Five-stage in-order RV32I integer core (IF/ID/EX/MEM/WB) with full EX forwarding,
// one-cycle load-use stall and branch/jump resolution in EX.
package rv32i_pkg;
  // Access size/sign, encoded exactly as the load/store funct3.
  typedef logic [2:0] mem_op_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic        vld;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_lui;
    logic        is_auipc;
    logic        use_imm;
    logic        sub_sra;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } idex_t;

  typedef struct packed {
    logic        vld;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] store_data;
  } exmem_t;

  typedef struct packed {
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } memwb_t;
endpackage

module rv32i_regfile (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      registers[waddr_i] <= wdata_i;
    end
  end

  // WB write is visible to the same-cycle ID read.
  always_comb begin
    rdata1_o = registers[raddr1_i];
    rdata2_o = registers[raddr2_i];
    if (we_i && waddr_i == raddr1_i) rdata1_o = wdata_i;
    if (we_i && waddr_i == raddr2_i) rdata2_o = wdata_i;
    if (raddr1_i == 5'd0) rdata1_o = '0;
    if (raddr2_i == 5'd0) rdata2_o = '0;
  end
endmodule

module rv32i_pipeline_core
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_if,
  output logic        mem_wr_en,
  output mem_op_t     mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d, id_dec;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;
  logic [31:0] id_ins, rf_rd1, rf_rd2;
  logic        stall, flush;
  logic [31:0] ex_a, ex_b_reg, ex_b, ex_sum, alu, ex_target, ex_result;
  logic        br_cond;

  assign pc_out = pc_q;
  assign id_ins = ifid_q.instr;

  rv32i_regfile register_file_h (
    .clk_i    (clk),
    .resetn_i (resetn),
    .we_i     (memwb_q.reg_we),
    .waddr_i  (memwb_q.rd),
    .wdata_i  (memwb_q.wdata),
    .raddr1_i (id_ins[19:15]),
    .raddr2_i (id_ins[24:20]),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  always_comb begin
    id_dec         = '0;
    id_dec.vld     = ifid_q.vld;
    id_dec.pc      = ifid_q.pc;
    id_dec.funct3  = id_ins[14:12];
    id_dec.rs1     = id_ins[19:15];
    id_dec.rs2     = id_ins[24:20];
    id_dec.rd      = id_ins[11:7];
    id_dec.rs1_val = rf_rd1;
    id_dec.rs2_val = rf_rd2;
    case (id_ins[6:0])
      OP_LUI:   begin id_dec.reg_we = 1'b1; id_dec.is_lui = 1'b1;   id_dec.imm = {id_ins[31:12], 12'b0}; end
      OP_AUIPC: begin id_dec.reg_we = 1'b1; id_dec.is_auipc = 1'b1; id_dec.imm = {id_ins[31:12], 12'b0}; end
      OP_JAL: begin
        id_dec.reg_we = 1'b1; id_dec.is_jal = 1'b1;
        id_dec.imm = {{11{id_ins[31]}}, id_ins[31], id_ins[19:12], id_ins[20], id_ins[30:21], 1'b0};
      end
      OP_JALR: begin
        id_dec.reg_we = 1'b1; id_dec.is_jalr = 1'b1;
        id_dec.imm = {{20{id_ins[31]}}, id_ins[31:20]};
      end
      OP_BR: begin
        id_dec.is_branch = 1'b1;
        id_dec.imm = {{19{id_ins[31]}}, id_ins[31], id_ins[7], id_ins[30:25], id_ins[11:8], 1'b0};
      end
      OP_LOAD: begin
        id_dec.reg_we = 1'b1; id_dec.is_load = 1'b1; id_dec.use_imm = 1'b1;
        id_dec.imm = {{20{id_ins[31]}}, id_ins[31:20]};
      end
      OP_STORE: begin
        id_dec.is_store = 1'b1; id_dec.use_imm = 1'b1;
        id_dec.imm = {{20{id_ins[31]}}, id_ins[31:25], id_ins[11:7]};
      end
      OP_IMM: begin
        id_dec.reg_we = 1'b1; id_dec.use_imm = 1'b1;
        id_dec.imm = {{20{id_ins[31]}}, id_ins[31:20]};
        // bit 30 is a real immediate bit for ADDI etc.; it only selects SRAI
        id_dec.sub_sra = id_ins[30] && (id_ins[14:12] == 3'b101);
      end
      OP_REG: begin id_dec.reg_we = 1'b1; id_dec.sub_sra = id_ins[30]; end
      default: ;
    endcase
    if (!ifid_q.vld) id_dec = '0;
  end

  assign stall = idex_q.vld && idex_q.is_load && (idex_q.rd != 5'd0) && ifid_q.vld &&
                 ((idex_q.rd == id_ins[19:15]) || (idex_q.rd == id_ins[24:20]));

  always_comb begin
    ex_a = idex_q.rs1_val;
    if (exmem_q.reg_we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1) ex_a = exmem_q.result;
    else if (memwb_q.reg_we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1) ex_a = memwb_q.wdata;
    ex_b_reg = idex_q.rs2_val;
    if (exmem_q.reg_we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2) ex_b_reg = exmem_q.result;
    else if (memwb_q.reg_we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2) ex_b_reg = memwb_q.wdata;
    ex_b   = idex_q.use_imm ? idex_q.imm : ex_b_reg;
    ex_sum = ex_a + idex_q.imm;

    case (idex_q.funct3)
      3'b000:  alu = idex_q.sub_sra ? ex_a - ex_b : ex_a + ex_b;
      3'b001:  alu = ex_a << ex_b[4:0];
      3'b010:  alu = {31'b0, $signed(ex_a) < $signed(ex_b)};
      3'b011:  alu = {31'b0, ex_a < ex_b};
      3'b100:  alu = ex_a ^ ex_b;
      3'b101:  alu = idex_q.sub_sra ? $unsigned($signed(ex_a) >>> ex_b[4:0]) : ex_a >> ex_b[4:0];
      3'b110:  alu = ex_a | ex_b;
      default: alu = ex_a & ex_b;
    endcase

    case (idex_q.funct3)
      3'b000:  br_cond = (ex_a == ex_b_reg);
      3'b001:  br_cond = (ex_a != ex_b_reg);
      3'b100:  br_cond = ($signed(ex_a) <  $signed(ex_b_reg));
      3'b101:  br_cond = ($signed(ex_a) >= $signed(ex_b_reg));
      3'b110:  br_cond = (ex_a <  ex_b_reg);
      3'b111:  br_cond = (ex_a >= ex_b_reg);
      default: br_cond = 1'b0;
    endcase

    flush     = idex_q.vld && (idex_q.is_jal || idex_q.is_jalr || (idex_q.is_branch && br_cond));
    ex_target = idex_q.is_jalr ? (ex_sum & ~32'd1) : idex_q.pc + idex_q.imm;

    if (idex_q.is_lui)                         ex_result = idex_q.imm;
    else if (idex_q.is_auipc)                  ex_result = idex_q.pc + idex_q.imm;
    else if (idex_q.is_jal || idex_q.is_jalr)  ex_result = idex_q.pc + 32'd4;
    else if (idex_q.is_load || idex_q.is_store) ex_result = ex_sum;
    else                                       ex_result = alu;
  end

  assign mem_wr_en   = exmem_q.vld && exmem_q.is_store && resetn;
  assign mem_op      = exmem_q.funct3;
  assign mem_addr    = exmem_q.result;
  assign mem_data_in = exmem_q.store_data;

  // Flush wins over stall: the stalled ID instruction is on the wrong path anyway.
  always_comb begin
    pc_d   = pc_q + 32'd4;
    ifid_d = '{vld: 1'b1, pc: pc_q, instr: instr_if};
    idex_d = id_dec;
    if (flush) begin
      pc_d   = ex_target;
      ifid_d = '0;
      idex_d = '0;
    end else if (stall) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end
    exmem_d = '{vld: idex_q.vld, reg_we: idex_q.reg_we, is_load: idex_q.is_load,
                is_store: idex_q.is_store, funct3: idex_q.funct3, rd: idex_q.rd,
                result: ex_result, store_data: ex_b_reg};
    memwb_d = '{reg_we: exmem_q.reg_we, rd: exmem_q.rd,
                wdata: exmem_q.is_load ? mem_data_out : exmem_q.result};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
endmodule

// File: tb/tb_rv32i_pipeline_core.sv
// Bench for rv32i_pipeline_core: directed program with instruction/data memory models,
// register-result table plus hand-written stall, flush, store and mid-program reset checks.
module tb_rv32i_pipeline_core;
  import rv32i_pkg::*;

  logic        clk, resetn;
  logic [31:0] pc_out, instr_if, mem_addr, mem_data_in, mem_data_out;
  logic        mem_wr_en;
  mem_op_t     mem_op;

  logic [31:0] imem [0:255];
  logic [7:0]  dmem [0:255];
  logic        dmem_clr, mon_en;
  logic [7:0]  da;
  int          n_vec, n_err;
  int          cnt20, cnt24, cnt28;
  logic [31:0] st_addr[$], st_data[$];
  mem_op_t     st_op[$];

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  rv32i_pipeline_core #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pc_out       (pc_out),
    .instr_if     (instr_if),
    .mem_wr_en    (mem_wr_en),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign instr_if = imem[pc_out[9:2]];
  assign da       = mem_addr[7:0];

  always_comb begin
    case (mem_op)
      3'b000:  mem_data_out = {{24{dmem[da][7]}}, dmem[da]};
      3'b001:  mem_data_out = {{16{dmem[da+8'd1][7]}}, dmem[da+8'd1], dmem[da]};
      3'b100:  mem_data_out = {24'b0, dmem[da]};
      3'b101:  mem_data_out = {16'b0, dmem[da+8'd1], dmem[da]};
      default: mem_data_out = {dmem[da+8'd3], dmem[da+8'd2], dmem[da+8'd1], dmem[da]};
    endcase
  end

  always @(posedge clk) begin
    if (dmem_clr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
    end else if (mem_wr_en) begin
      dmem[da] <= mem_data_in[7:0];
      if (mem_op[1:0] != 2'b00) dmem[da+8'd1] <= mem_data_in[15:8];
      if (mem_op[1]) begin
        dmem[da+8'd2] <= mem_data_in[23:16];
        dmem[da+8'd3] <= mem_data_in[31:24];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (pc_out == 32'h20) cnt20++;
      if (pc_out == 32'h24) cnt24++;
      if (pc_out == 32'h28) cnt28++;
      if (mem_wr_en) begin
        st_addr.push_back(mem_addr);
        st_data.push_back(mem_data_in);
        st_op.push_back(mem_op);
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [31:0] imm,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.register_file_h.registers[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic load_prog();
    localparam logic [6:0] OI = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[0]  = enc_u(7'b0110111, 5'd10, 20'hABCDE);       // LUI x10
    imem[1]  = enc_i(3'b000, 5'd0, 5'd0, 32'd0, OI);      // NOP
    imem[2]  = enc_u(7'b0010111, 5'd11, 20'h11111);       // AUIPC x11 @8
    imem[3]  = enc_i(3'b000, 5'd1, 5'd0, 32'd5, OI);
    imem[4]  = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);    // ADD x2,x1,x1
    imem[5]  = enc_s(3'b010, 5'd2, 5'd0, 32'd0);          // SW x2,0(x0)
    imem[6]  = enc_i(3'b010, 5'd3, 5'd0, 32'd0, LD);      // LW x3
    imem[7]  = enc_i(3'b000, 5'd4, 5'd3, 32'd1, OI);      // load-use
    imem[8]  = enc_j(5'd1, 32'd8);                        // JAL x1,+8 @0x20
    imem[9]  = enc_i(3'b000, 5'd5, 5'd0, 32'd99, OI);
    imem[10] = enc_i(3'b000, 5'd0, 5'd0, 32'd7, OI);      // ADDI x0
    imem[11] = enc_b(3'b000, 5'd0, 5'd0, 32'd12);         // BEQ +12
    imem[12] = enc_i(3'b000, 5'd6, 5'd0, 32'd1, OI);
    imem[13] = enc_i(3'b000, 5'd7, 5'd0, 32'd1, OI);
    imem[14] = enc_i(3'b000, 5'd8, 5'd0, 32'h55, OI);
    imem[15] = enc_i(3'b000, 5'd9, 5'd0, 32'hFFFF_FFF0, OI);
    imem[16] = enc_r(7'h20, 5'd9, 5'd8, 3'b000, 5'd12);   // SUB
    imem[17] = enc_i(3'b101, 5'd13, 5'd9, 32'h402, OI);   // SRAI 2
    imem[18] = enc_i(3'b101, 5'd14, 5'd9, 32'd28, OI);    // SRLI 28
    imem[19] = enc_r(7'h00, 5'd8, 5'd9, 3'b010, 5'd15);   // SLT
    imem[20] = enc_r(7'h00, 5'd8, 5'd9, 3'b011, 5'd16);   // SLTU
    imem[21] = enc_i(3'b100, 5'd17, 5'd9, 32'hFFFF_FFFF, OI);
    imem[22] = enc_s(3'b000, 5'd9, 5'd0, 32'd4);          // SB
    imem[23] = enc_i(3'b000, 5'd18, 5'd0, 32'd4, LD);     // LB
    imem[24] = enc_i(3'b100, 5'd19, 5'd0, 32'd4, LD);     // LBU
    imem[25] = enc_b(3'b001, 5'd0, 5'd0, 32'd8);          // BNE not taken
    imem[26] = enc_i(3'b000, 5'd20, 5'd0, 32'd3, OI);
    imem[27] = enc_i(3'b000, 5'd21, 5'd0, 32'h79, 7'b1100111); // JALR -> 0x78
    imem[28] = enc_i(3'b000, 5'd22, 5'd0, 32'd1, OI);
    imem[29] = enc_i(3'b000, 5'd23, 5'd0, 32'd1, OI);
    imem[30] = enc_r(7'h00, 5'd20, 5'd20, 3'b001, 5'd24); // SLL
    imem[31] = enc_r(7'h20, 5'd20, 5'd9, 3'b101, 5'd25);  // SRA
    imem[32] = enc_b(3'b100, 5'd9, 5'd0, 32'd8);          // BLT taken
    imem[33] = enc_i(3'b000, 5'd26, 5'd0, 32'd1, OI);
    imem[34] = enc_b(3'b111, 5'd9, 5'd0, 32'd8);          // BGEU taken
    imem[35] = enc_i(3'b000, 5'd27, 5'd0, 32'd1, OI);
    imem[36] = enc_j(5'd0, 32'd0);                        // spin
  endtask

  task automatic run_to_end(input string name);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      if (pc_out == 32'h90) hit = 1'b1;
    end
    check(name, {31'b0, hit}, 32'd1);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_regs_zero(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf(i) !== 32'h0) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    logic hit;
    n_vec = 0; n_err = 0; cnt20 = 0; cnt24 = 0; cnt28 = 0;
    mon_en = 1'b0; resetn = 1'b0; dmem_clr = 1'b1;
    vecs.push_back('{"x0_write_discarded", 0, 32'h0});
    vecs.push_back('{"x1_jal_link",        1, 32'h24});
    vecs.push_back('{"x2_fwd_add",         2, 32'hA});
    vecs.push_back('{"x3_lw",              3, 32'hA});
    vecs.push_back('{"x4_load_use",        4, 32'hB});
    vecs.push_back('{"x5_jal_shadow",      5, 32'h0});
    vecs.push_back('{"x6_beq_flush1",      6, 32'h0});
    vecs.push_back('{"x7_beq_flush2",      7, 32'h0});
    vecs.push_back('{"x8_beq_target",      8, 32'h55});
    vecs.push_back('{"x9_addi_neg",        9, 32'hFFFF_FFF0});
    vecs.push_back('{"x10_lui",           10, 32'hABCD_E000});
    vecs.push_back('{"x11_auipc",         11, 32'h1111_1008});
    vecs.push_back('{"x12_sub",           12, 32'h65});
    vecs.push_back('{"x13_srai",          13, 32'hFFFF_FFFC});
    vecs.push_back('{"x14_srli",          14, 32'hF});
    vecs.push_back('{"x15_slt",           15, 32'h1});
    vecs.push_back('{"x16_sltu",          16, 32'h0});
    vecs.push_back('{"x17_xori",          17, 32'hF});
    vecs.push_back('{"x18_lb",            18, 32'hFFFF_FFF0});
    vecs.push_back('{"x19_lbu",           19, 32'hF0});
    vecs.push_back('{"x20_bne_fallthru",  20, 32'h3});
    vecs.push_back('{"x21_jalr_link",     21, 32'h70});
    vecs.push_back('{"x22_jalr_flush1",   22, 32'h0});
    vecs.push_back('{"x23_jalr_flush2",   23, 32'h0});
    vecs.push_back('{"x24_sll",           24, 32'h18});
    vecs.push_back('{"x25_sra",           25, 32'hFFFF_FFFE});
    vecs.push_back('{"x26_blt_flush",     26, 32'h0});
    vecs.push_back('{"x27_bgeu_flush",    27, 32'h0});
    load_prog();

    repeat (2) @(posedge clk);
    @(negedge clk);
    dmem_clr = 1'b0;
    check("rst_pc", pc_out, 32'h0);
    check("rst_wr_en", {31'b0, mem_wr_en}, 32'h0);
    check_regs_zero("rst_regs_zero");
    resetn = 1'b1;
    mon_en = 1'b1;

    run_to_end("run1_reach_end");
    mon_en = 1'b0;
    foreach (vecs[i]) check(vecs[i].name, rf(vecs[i].idx), vecs[i].exp);

    check("stall_pc20_cycles", 32'(cnt20), 32'd2);
    check("jal_shadow_fetch",  32'(cnt24), 32'd1);
    check("jal_target_refetch", 32'(cnt28), 32'd2);
    check("store_count", 32'(st_addr.size()), 32'd2);
    if (st_addr.size() == 2) begin
      check("sw_addr", st_addr[0], 32'h0);
      check("sw_data", st_data[0], 32'hA);
      check("sw_op",   {29'b0, st_op[0]}, 32'h2);
      check("sb_addr", st_addr[1], 32'h4);
      check("sb_data", st_data[1], 32'hFFFF_FFF0);
      check("sb_op",   {29'b0, st_op[1]}, 32'h0);
    end
    check("dmem_word0", {dmem[3], dmem[2], dmem[1], dmem[0]}, 32'hA);
    check("dmem_byte4", {24'b0, dmem[4]}, 32'hF0);

    // Restart, then pull reset low in the very cycle the SW is in MEM.
    resetn = 1'b0; dmem_clr = 1'b1;
    repeat (2) @(negedge clk);
    dmem_clr = 1'b0;
    resetn = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (mem_wr_en) hit = 1'b1;
    end
    check("rst6_store_reached", {31'b0, hit}, 32'd1);
    resetn = 1'b0;
    #1;
    check("rst6_wr_gated", {31'b0, mem_wr_en}, 32'h0);
    @(negedge clk);
    check("rst6_pc", pc_out, 32'h0);
    check("rst6_wr_after", {31'b0, mem_wr_en}, 32'h0);
    check_regs_zero("rst6_regs_zero");
    check("rst6_no_store", {dmem[3], dmem[2], dmem[1], dmem[0]}, 32'h0);
    resetn = 1'b1;

    run_to_end("run2_reach_end");
    check("run2_x4", rf(4), 32'hB);
    check("run2_x11", rf(11), 32'h1111_1008);
    check("run2_dmem_word0", {dmem[3], dmem[2], dmem[1], dmem[0]}, 32'hA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
